// File: rtl/dif_r2_pkg.sv
// Shared types and elaboration helpers for the radix-2 DIF SDF pipeline controller.
//   state_e      : controller FSM states
//   bitrev       : reverses the low log2n bits of x
//   stage_delay  : sample delay from the pipeline input to stage j
//   total_delay  : delay from the input to the data arranger (stage 0)
package dif_r2_pkg;

  localparam int unsigned MAX_LOG2N = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WARM  = 2'd1,
    S_PRIME = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  // Reverse the low log2n bits of x; bits above log2n come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] x,
                                                  input int unsigned log2n);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < MAX_LOG2N; b++) begin
      if (b < log2n) r[4'(b)] = x[4'(log2n - 1 - b)];
    end
    return r;
  endfunction

  // Stages ahead of the twiddle multiplier also carry its latency.
  function automatic int unsigned stage_delay(input int unsigned j,
                                              input int unsigned log2n,
                                              input int unsigned tm_split,
                                              input int unsigned tm_delay);
    return (log2n - 1 - j) + ((j < tm_split) ? tm_delay : 32'd0);
  endfunction

  function automatic int unsigned total_delay(input int unsigned log2n,
                                              input int unsigned tm_split,
                                              input int unsigned tm_delay);
    return stage_delay(32'd0, log2n, tm_split, tm_delay);
  endfunction

endpackage

// File: rtl/dif_r2_pipe_ctrl_if.sv
// Control bus between the sample source, the FFT controller and the datapath.
//   din_valid, flush         : source -> controller
//   pe_mux_ctrl, tm_ctrl     : stage mux selects / twiddle index (combinational)
//   da_addr, da_wen, da_ren  : data-arranger RAM access (combinational)
//   dout_valid/sop/eop       : registered output framing
interface dif_r2_pipe_ctrl_if #(
  parameter int unsigned LOG2N = 6
);
  logic             din_valid;
  logic             flush;
  logic [LOG2N-1:0] pe_mux_ctrl;
  logic [LOG2N-1:0] tm_ctrl;
  logic [LOG2N-1:0] da_addr;
  logic             da_wen;
  logic             da_ren;
  logic             dout_valid;
  logic             dout_sop;
  logic             dout_eop;

  modport master (
    output din_valid, flush,
    input  pe_mux_ctrl, tm_ctrl, da_addr, da_wen, da_ren,
    input  dout_valid, dout_sop, dout_eop
  );

  modport slave (
    input  din_valid, flush,
    output pe_mux_ctrl, tm_ctrl, da_addr, da_wen, da_ren,
    output dout_valid, dout_sop, dout_eop
  );
endinterface

// File: rtl/dif_r2_da_agen.sv
// Data-arranger address generator: in-frame index, frame parity and the
// natural / bit-reversed address mux. Parity flips on every index wrap so
// consecutive frames alternate the two address orders.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance one sample
//   clr        : synchronous clear (wins over en)
//   idx        : current in-frame index
//   addr_c     : RAM address for the current index
//   last_c     : index is the last of the frame
module dif_r2_da_agen
  import dif_r2_pkg::*;
#(
  parameter int unsigned LOG2N = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [LOG2N-1:0] idx,
  output logic [LOG2N-1:0] addr_c,
  output logic             last_c
);

  logic [LOG2N-1:0] idx_d;
  logic             par_q;
  logic             par_d;

  assign last_c = (idx == '1);
  assign addr_c = par_q ? LOG2N'(bitrev(MAX_LOG2N'(idx), LOG2N)) : idx;

  // Next index / parity
  always_comb begin
    idx_d = idx;
    par_d = par_q;
    if (clr) begin
      idx_d = '0;
      par_d = 1'b0;
    end else if (en) begin
      idx_d = idx + 1'b1;
      if (last_c) par_d = ~par_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      par_q <= 1'b0;
    end else begin
      idx   <= idx_d;
      par_q <= par_d;
    end
  end

endmodule

// File: rtl/dif_r2_pipe_ctrl.sv
// Controller for an N = 2^LOG2N point radix-2 DIF single-path delay-feedback
// FFT: stage mux selects, twiddle index and the bit-reversal data arranger.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of dif_r2_pipe_ctrl_if (din_valid/flush in;
//                mux selects, twiddle index, DA strobes/address, framing out)
module dif_r2_pipe_ctrl
  import dif_r2_pkg::*;
#(
  parameter int unsigned LOG2N    = 6,
  parameter int unsigned TM_DELAY = 1,
  parameter int unsigned TM_SPLIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  dif_r2_pipe_ctrl_if.slave bus
);

  localparam int unsigned D      = total_delay(LOG2N, TM_SPLIT, TM_DELAY);
  localparam int unsigned TM_OFS = LOG2N - TM_SPLIT;

  localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
  localparam logic [1:0] ST_WARM  = 2'(S_WARM);
  localparam logic [1:0] ST_PRIME = 2'(S_PRIME);
  localparam logic [1:0] ST_RUN   = 2'(S_RUN);

  logic [1:0]       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_sop_q, dout_sop_d;
  logic             dout_eop_q, dout_eop_d;
  logic             wr_c, rd_c;
  logic [LOG2N-1:0] pe_c;
  logic [LOG2N-1:0] da_idx;
  logic [LOG2N-1:0] da_addr_c;
  logic             da_last_c;

  dif_r2_da_agen #(
    .LOG2N (LOG2N)
  ) u_agen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (wr_c),
    .clr    (bus.flush),
    .idx    (da_idx),
    .addr_c (da_addr_c),
    .last_c (da_last_c)
  );

  // Stage j sees the sample that entered d_j samples ago
  always_comb begin
    pe_c = '0;
    for (int unsigned j = 0; j < LOG2N; j++) begin
      pe_c = pe_c | ((cnt_q - LOG2N'(stage_delay(j, LOG2N, TM_SPLIT, TM_DELAY)))
                     & (LOG2N'(1) << j));
    end
  end

  // Next state, counter, DA strobes and output framing
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_c         = 1'b0;
    rd_c         = 1'b0;
    dout_valid_d = 1'b0;
    dout_sop_d   = 1'b0;
    dout_eop_d   = 1'b0;
    if (!rst_n || bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (bus.din_valid) begin
      cnt_d = cnt_q + 1'b1;
      wr_c  = (state_q == ST_PRIME) || (state_q == ST_RUN);
      rd_c  = (state_q == ST_RUN);
      case (state_q)
        ST_IDLE:  state_d = (D == 32'd1) ? ST_PRIME : ST_WARM;
        ST_WARM:  if (cnt_q == LOG2N'(D - 1)) state_d = ST_PRIME;
        ST_PRIME: if (da_last_c) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
    dout_valid_d = rd_c;
    dout_sop_d   = rd_c & (da_idx == '0);
    dout_eop_d   = rd_c & da_last_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_sop_q   <= dout_sop_d;
      dout_eop_q   <= dout_eop_d;
    end
  end

  assign bus.pe_mux_ctrl = pe_c;
  assign bus.tm_ctrl     = cnt_q - LOG2N'(TM_OFS);
  assign bus.da_addr     = da_addr_c;
  assign bus.da_wen      = wr_c;
  assign bus.da_ren      = rd_c;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.dout_sop    = dout_sop_q;
  assign bus.dout_eop    = dout_eop_q;

endmodule

// File: tb/tb_dif_r2_pipe_ctrl.sv
// Bench for dif_r2_pipe_ctrl: two configurations (64-point D=6, 16-point D=5)
// against a sample-count model, plus a read-before-write DA RAM model on the
// 64-point instance carrying bit-reversed input frames.
module tb_dif_r2_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic valid;
  logic flush;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  dif_r2_pipe_ctrl_if #(.LOG2N(6)) bus_a ();
  dif_r2_pipe_ctrl_if #(.LOG2N(4)) bus_b ();

  assign bus_a.din_valid = valid;
  assign bus_a.flush     = flush;
  assign bus_b.din_valid = valid;
  assign bus_b.flush     = flush;

  dif_r2_pipe_ctrl #(.LOG2N(6), .TM_DELAY(1), .TM_SPLIT(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dif_r2_pipe_ctrl #(.LOG2N(4), .TM_DELAY(2), .TM_SPLIT(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int unsigned m_bitrev(input int unsigned x, input int unsigned l);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < l; b++)
      if (((x >> b) & 1) != 0) r = r | (32'd1 << (l - 1 - b));
    return r;
  endfunction

  function automatic int unsigned m_delay(input int unsigned l, input int unsigned t,
                                          input int unsigned s, input int unsigned j);
    return (l - 1 - j) + ((j < s) ? t : 0);
  endfunction

  // Expected combinational outputs from k = accepted samples since reset/flush.
  task automatic check_comb(input string tag, input int unsigned l, input int unsigned t,
                            input int unsigned s, input int unsigned k, input logic act,
                            input int unsigned pe, input int unsigned tm,
                            input int unsigned addr, input logic wen, input logic ren,
                            output logic er, output int unsigned idx);
    int unsigned n, d, pos, par, exp_pe, v;
    logic ew;
    n   = 32'd1 << l;
    d   = m_delay(l, t, s, 0);
    ew  = act && (k >= d);
    er  = act && (k >= d + n);
    pos = (k >= d) ? k - d : 0;
    idx = pos % n;
    par = (pos / n) % 2;
    exp_pe = 0;
    for (int unsigned j = 0; j < l; j++) begin
      v = (k + 4 * n - m_delay(l, t, s, j)) % n;
      if (((v >> j) & 1) != 0) exp_pe = exp_pe | (32'd1 << j);
    end
    check({tag, ".da_wen"}, 32'(wen), 32'(ew));
    check({tag, ".da_ren"}, 32'(ren), 32'(er));
    check({tag, ".pe_mux_ctrl"}, pe, exp_pe);
    check({tag, ".tm_ctrl"}, tm, (k + n - (l - s)) % n);
    if (ew || (k == 0 && act))
      check({tag, ".da_addr"}, addr, (par != 0) ? m_bitrev(idx, l) : idx);
  endtask

  // ---------------- configuration A: 64-point, D=6, with RAM model ----------------
  int unsigned k_a = 0;
  int unsigned out_n_a = 0;
  int unsigned i_a;
  int unsigned rdata_a = 0;
  int unsigned mem_a [64];
  logic er_a;
  logic edv_a = 1'b0, esop_a = 1'b0, eeop_a = 1'b0, pacc_a = 1'b0;
  logic acc;

  assign acc = rst_n && valid && !flush;

  function automatic int unsigned wdata_a(input int unsigned k);
    return (((k - 6) / 64) << 8) | m_bitrev((k - 6) % 64, 6);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check_comb("A", 6, 1, 3, k_a, acc, 32'(bus_a.pe_mux_ctrl), 32'(bus_a.tm_ctrl),
                 32'(bus_a.da_addr), bus_a.da_wen, bus_a.da_ren, er_a, i_a);
      check("A.dout_valid", 32'(bus_a.dout_valid), 32'(edv_a));
      check("A.dout_sop", 32'(bus_a.dout_sop), 32'(esop_a));
      check("A.dout_eop", 32'(bus_a.dout_eop), 32'(eeop_a));
      if (edv_a) begin
        check("A.data", rdata_a, ((out_n_a / 64) << 8) | (out_n_a % 64));
        out_n_a++;
      end
      if (bus_a.da_wen) begin
        if (bus_a.da_ren) rdata_a = mem_a[bus_a.da_addr];
        mem_a[bus_a.da_addr] = wdata_a(k_a);
      end
      if (acc) begin
        case (k_a)
          3:   check("A.lit tm k3", 32'(bus_a.tm_ctrl), 0);
          5:   check("A.lit wen k5", 32'(bus_a.da_wen), 0);
          6: begin
            check("A.lit wen k6", 32'(bus_a.da_wen), 1);
            check("A.lit addr k6", 32'(bus_a.da_addr), 0);
          end
          10:  check("A.lit pe0 k10", 32'(bus_a.pe_mux_ctrl[0]), 0);
          11:  check("A.lit pe0 k11", 32'(bus_a.pe_mux_ctrl[0]), 1);
          16: begin
            check("A.lit pe5 k16", 32'(bus_a.pe_mux_ctrl[5]), 0);
            check("A.lit pe4 k16", 32'(bus_a.pe_mux_ctrl[4]), 0);
          end
          17:  check("A.lit pe4 k17", 32'(bus_a.pe_mux_ctrl[4]), 1);
          69: begin
            check("A.lit addr k69", 32'(bus_a.da_addr), 63);
            check("A.lit ren k69", 32'(bus_a.da_ren), 0);
          end
          70: begin
            check("A.lit ren k70", 32'(bus_a.da_ren), 1);
            check("A.lit addr k70", 32'(bus_a.da_addr), 0);
          end
          71: begin
            check("A.lit addr k71", 32'(bus_a.da_addr), 32);
            check("A.lit sop k71", 32'(bus_a.dout_sop), 1);
            check("A.lit dv k71", 32'(bus_a.dout_valid), 1);
          end
          90: begin
            check("A.lit addr i20", 32'(bus_a.da_addr), 10);
            check("A.lit ren i20", 32'(bus_a.da_ren), 1);
          end
          134: check("A.lit eop k134", 32'(bus_a.dout_eop), 1);
          default: ;
        endcase
      end
      if (rst_n && !valid && k_a == 90) begin
        check("A.lit stall wen", 32'(bus_a.da_wen), 0);
        check("A.lit stall ren", 32'(bus_a.da_ren), 0);
      end
      if (rst_n && flush) begin
        check("A.lit flush wen", 32'(bus_a.da_wen), 0);
        check("A.lit flush ren", 32'(bus_a.da_ren), 0);
      end
      if (!pacc_a) check("A.lit dv after idle", 32'(bus_a.dout_valid), 0);
      edv_a  = er_a;
      esop_a = er_a && (i_a == 0);
      eeop_a = er_a && (i_a == 63);
      pacc_a = acc;
    end
    if (!rst_n || flush) begin
      k_a     = 0;
      out_n_a = 0;
    end else if (valid) begin
      k_a++;
    end
  end

  // ---------------- configuration B: 16-point, D=5 ----------------
  int unsigned k_b = 0;
  int unsigned i_b;
  logic er_b;
  logic edv_b = 1'b0, esop_b = 1'b0, eeop_b = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      check_comb("B", 4, 2, 2, k_b, acc, 32'(bus_b.pe_mux_ctrl), 32'(bus_b.tm_ctrl),
                 32'(bus_b.da_addr), bus_b.da_wen, bus_b.da_ren, er_b, i_b);
      check("B.dout_valid", 32'(bus_b.dout_valid), 32'(edv_b));
      check("B.dout_sop", 32'(bus_b.dout_sop), 32'(esop_b));
      check("B.dout_eop", 32'(bus_b.dout_eop), 32'(eeop_b));
      if (acc) begin
        case (k_b)
          4:  check("B.lit wen k4", 32'(bus_b.da_wen), 0);
          5: begin
            check("B.lit wen k5", 32'(bus_b.da_wen), 1);
            check("B.lit addr k5", 32'(bus_b.da_addr), 0);
          end
          20: check("B.lit ren k20", 32'(bus_b.da_ren), 0);
          21: begin
            check("B.lit ren k21", 32'(bus_b.da_ren), 1);
            check("B.lit addr k21", 32'(bus_b.da_addr), 0);
          end
          22: begin
            check("B.lit ren k22", 32'(bus_b.da_ren), 1);
            check("B.lit addr k22", 32'(bus_b.da_addr), 8);
          end
          default: ;
        endcase
      end
      edv_b  = er_b;
      esop_b = er_b && (i_b == 0);
      eeop_b = er_b && (i_b == 15);
    end
    if (!rst_n || flush) k_b = 0;
    else if (valid) k_b++;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1 chk_on = 1'b1;
    @(posedge clk);
    // continuous run into RUN, 3-cycle stall at frame 1 index 20
    #1 rst_n = 1'b1; valid = 1'b1;
    repeat (90) @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 valid = 1'b1;
    repeat (84) @(posedge clk);
    // flush at frame 2 index 40, one idle cycle, then restart
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; valid = 1'b0;
    @(posedge clk);
    #1 valid = 1'b1;
    repeat (140) @(posedge clk);
    // reset mid-frame, then four full frames through the arranger
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (264) @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
